// File: rtl/spi_host_xfer.sv
// SPI mode-0 host: bytes in on a valid/ready port, shifted MSB first on sck/mosi,
// miso sampled on rising SCK; tx_last_i closes the CSB frame.
module spi_host_xfer #(
    parameter int HalfPeriod = 2,
    parameter int CsbIdle    = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_last_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    output logic       busy_o,
    output logic       spi_sck_o,
    output logic       spi_csb_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i
);

    localparam int CntMax = (HalfPeriod > CsbIdle) ? HalfPeriod : CsbIdle;
    localparam int CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] HalfLoad = CntW'(HalfPeriod - 1);
    localparam logic [CntW-1:0] IdleLoad = CntW'(CsbIdle - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD, GAP} state_e;

    state_e          state;
    logic [CntW-1:0] cnt;
    logic [3:0]      bit_cnt;
    logic            last;
    logic [6:0]      tx_shift;
    logic [7:0]      rx_shift;
    logic            xfer;
    logic            half_done;
    logic            rise_ev;
    logic            fall_ev;

    assign tx_ready_o = (state == IDLE) || (state == WAIT);
    assign busy_o     = (state != IDLE);
    assign xfer       = tx_valid_i & tx_ready_o;
    assign half_done  = (state == SHIFT) && (cnt == '0);
    assign rise_ev    = half_done & ~spi_sck_o;
    assign fall_ev    = half_done & spi_sck_o;

    // Shift registers carry data only; a fresh byte always overwrites every bit before use.
    always_ff @(posedge clk_i) begin
        if (xfer) begin
            tx_shift <= tx_data_i[6:0];
        end else if (fall_ev) begin
            tx_shift <= {tx_shift[5:0], 1'b0};
        end
        if (rise_ev) begin
            rx_shift <= {rx_shift[6:0], spi_miso_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            last       <= 1'b0;
            spi_sck_o  <= 1'b0;
            spi_csb_o  <= 1'b1;
            spi_mosi_o <= 1'b0;
            rx_valid_o <= 1'b0;
            rx_data_o  <= '0;
        end else begin
            rx_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        last       <= tx_last_i;
                        spi_csb_o  <= 1'b0;
                        spi_mosi_o <= tx_data_i[7];
                        cnt        <= HalfLoad;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        cnt     <= HalfLoad;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SHIFT: begin
                    // Each byte is 16 half-periods starting low; the 16th ends on the 8th fall.
                    if (cnt == '0) begin
                        cnt     <= HalfLoad;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (!spi_sck_o) begin
                            spi_sck_o <= 1'b1;
                        end else begin
                            spi_sck_o <= 1'b0;
                            if (bit_cnt == 4'd15) begin
                                rx_data_o  <= rx_shift;
                                rx_valid_o <= 1'b1;
                                state      <= last ? HOLD : WAIT;
                            end else begin
                                spi_mosi_o <= tx_shift[6];
                            end
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT: begin
                    if (xfer) begin
                        last       <= tx_last_i;
                        spi_mosi_o <= tx_data_i[7];
                        cnt        <= HalfLoad;
                        bit_cnt    <= '0;
                        state      <= SHIFT;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        spi_csb_o <= 1'b1;
                        cnt       <= IdleLoad;
                        state     <= GAP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
